// File: rtl/lsu_controller.sv
// Load/store sequencer: issues one request/grant/response data-bus transaction per access,
// stalls the core while it is in flight and returns the extended load result or a fault pulse.
module lsu_controller #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_read_en_i,
  input  logic            mem_write_en_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_sign_ext_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            load_valid_o,
  output logic            misaligned_o,
  output logic            bus_err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_be_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [3:0]      be_q;
  logic [1:0]      size_q, off_q;
  logic            we_q, sx_q, is_load_q, err_q;

  logic            access, misaligned, idle;
  logic [1:0]      off;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n, lane, load_ext;

  assign access = mem_read_en_i | mem_write_en_i;
  assign off    = addr_i[1:0];
  assign idle   = (state_q == StIdle);

  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = store_data_i;
    case (mem_size_i)
      2'b00: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misaligned = off[0];
        be_n       = 4'b0011 << off;
        wdata_n    = {2{store_data_i[15:0]}};
      end
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane-select and extend the response using the attributes latched at issue.
  always_comb begin
    lane     = dbus_rdata_i >> {off_q, 3'b000};
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){sx_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{(XLEN-16){sx_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  assign misaligned_o = ~rst_i & idle & access & misaligned;
  assign stall_o      = ~rst_i & ((idle & access & ~misaligned) |
                                  (state_q == StReq) | (state_q == StWait));
  assign dbus_req_o   = (state_q == StReq);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_be_o    = be_q;
  assign load_valid_o = (state_q == StDone) & is_load_q & ~err_q;
  assign bus_err_o    = (state_q == StDone) & err_q;
  assign load_data_o  = load_valid_o ? load_data_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      be_q        <= '0;
      size_q      <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      sx_q        <= 1'b0;
      is_load_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access && !misaligned) begin
            addr_q      <= {addr_i[XLEN-1:2], 2'b00};
            wdata_q     <= wdata_n;
            be_q        <= be_n;
            we_q        <= mem_write_en_i;
            size_q      <= mem_size_i;
            sx_q        <= mem_sign_ext_i;
            off_q       <= off;
            is_load_q   <= mem_read_en_i & ~mem_write_en_i;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (dbus_gnt_i) begin
            state_q <= StWait;
          end else if (cnt_q == CntMax) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
          // Saturate so a grant on the last budget cycle cannot restart the count.
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
        end
        StWait: begin
          if (dbus_rvalid_i) begin
            err_q       <= dbus_err_i;
            load_data_q <= load_ext;
            state_q     <= StDone;
          end else if (cnt_q == CntMax) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: expected retire outcomes are queued at issue and
// compared when the DUT reaches its retire cycle.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sx;
  logic [1:0]  sz;
  logic [31:0] addr, sdata;
  logic        stall, lvalid, mis, berr, req, we, gnt, rvalid, rerr;
  logic [31:0] ldata, baddr, bwdata, rdata;
  logic [3:0]  be;

  typedef struct packed {
    logic [1:0]  kind;  // 0 silent retire, 1 load result, 2 bus error
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu_controller #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_read_en_i(rd), .mem_write_en_i(wr), .mem_size_i(sz), .mem_sign_ext_i(sx),
    .addr_i(addr), .store_data_i(sdata),
    .stall_o(stall), .load_data_o(ldata), .load_valid_o(lvalid), .misaligned_o(mis),
    .bus_err_o(berr), .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(baddr),
    .dbus_wdata_o(bwdata), .dbus_be_o(be), .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid),
    .dbus_rdata_i(rdata), .dbus_err_i(rerr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_retire(input string tag);
    exp_t e;
    chk({tag, "_queue_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_stall_done"}, 32'(stall), 32'd0);
      chk({tag, "_load_valid"}, 32'(lvalid), 32'(e.kind == 2'd1));
      chk({tag, "_bus_err"}, 32'(berr), 32'(e.kind == 2'd2));
      chk({tag, "_load_data"}, ldata, (e.kind == 2'd1) ? e.data : 32'h0);
    end
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic access(input string tag, input logic r, input logic w, input logic [1:0] s,
                        input logic x, input logic [31:0] a, input logic [31:0] d,
                        input int gnt_dly, input int rv_dly, input logic [31:0] resp,
                        input logic resp_err, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [1:0] exp_kind,
                        input logic [31:0] exp_data);
    rd = r; wr = w; sz = s; sx = x; addr = a; sdata = d;
    sb_q.push_back('{kind: exp_kind, data: exp_data});
    @(negedge clk);
    chk({tag, "_t0_stall"}, 32'(stall), 32'd1);
    chk({tag, "_t0_req"}, 32'(req), 32'd0);
    tick();
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i <= gnt_dly; i++) begin
      gnt = (i == gnt_dly);
      @(negedge clk);
      chk({tag, "_req"}, 32'(req), 32'd1);
      chk({tag, "_req_stall"}, 32'(stall), 32'd1);
      chk({tag, "_addr"}, baddr, {a[31:2], 2'b00});
      chk({tag, "_be"}, 32'(be), 32'(exp_be));
      chk({tag, "_we"}, 32'(we), 32'(w));
      if (w) chk({tag, "_wdata"}, bwdata, exp_wdata);
      tick();
    end
    gnt = 1'b0;
    for (int j = 0; j <= rv_dly; j++) begin
      rvalid = (j == rv_dly); rdata = resp; rerr = resp_err;
      @(negedge clk);
      chk({tag, "_wait_req"}, 32'(req), 32'd0);
      chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
      tick();
    end
    rvalid = 1'b0; rerr = 1'b0; rdata = 32'h0;
    @(negedge clk);
    check_retire(tag);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sz = 2'b00; sx = 1'b0; addr = '0; sdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; rerr = 1'b0;
    rd = 1'b1; addr = 32'h100; sz = 2'b10;  // access pending while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_outs", {ldata | baddr | bwdata}, 32'h0);
    chk("rst_pulses", 32'({lvalid, berr, we, be}), 32'd0);
    tick();
    rd = 1'b0;
    rst = 1'b0;
    tick();

    access("lw", 1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0,
           4'b1111, 32'h0, 2'd1, 32'hDEADBEEF);
    access("lb", 1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF, 0,
           4'b1000, 32'h0, 2'd1, 32'hFFFFFF80);
    access("lbu", 1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF, 0,
           4'b1000, 32'h0, 2'd1, 32'h00000080);
    access("sh", 0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 3, 0, 32'h0, 0,
           4'b1100, 32'hABCDABCD, 2'd0, 32'h0);
    access("lh", 1, 0, 2'b01, 1, 32'h002, 32'h0, 1, 2, 32'h8001_1234, 0,
           4'b1100, 32'h0, 2'd1, 32'hFFFF8001);
    access("lhu", 1, 0, 2'b01, 0, 32'h000, 32'h0, 0, 1, 32'h8001_F00D, 0,
           4'b0011, 32'h0, 2'd1, 32'h0000F00D);
    access("sb_rw", 1, 1, 2'b00, 0, 32'h001, 32'hAA55, 0, 0, 32'h12345678, 0,
           4'b0010, 32'h55555555, 2'd0, 32'h0);
    access("lw_err", 1, 0, 2'b10, 0, 32'h010, 32'h0, 0, 1, 32'h12345678, 1,
           4'b1111, 32'h0, 2'd2, 32'h0);

    // Misaligned: flagged in the issue cycle, no stall, no bus request.
    for (int k = 0; k < 3; k++) begin
      rd = 1'b1;
      case (k)
        0: begin sz = 2'b10; addr = 32'h101; end
        1: begin sz = 2'b01; addr = 32'h203; end
        default: begin sz = 2'b11; addr = 32'h300; end
      endcase
      @(negedge clk);
      chk("mis_flag", 32'(mis), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_req", 32'(req), 32'd0);
      tick();
      rd = 1'b0;
      @(negedge clk);
      chk("mis_after_req", 32'(req), 32'd0);
      chk("mis_after_flag", 32'(mis), 32'd0);
      tick();
    end

    // Timeout: no grant ever.
    rd = 1'b1; sz = 2'b10; addr = 32'h40;
    sb_q.push_back('{kind: 2'd2, data: 32'h0});
    @(negedge clk);
    chk("to_t0_stall", 32'(stall), 32'd1);
    tick();
    rd = 1'b0;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!req) break;
      n_req++;
      chk("to_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("to_req_cycles", 32'(n_req), 32'd8);
    check_retire("to");
    tick();

    // Reset in WAIT, then a stale response after release.
    rd = 1'b1; sz = 2'b10; addr = 32'h80;
    @(negedge clk);
    tick();
    rd = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_req", 32'(req), 32'd0);
    chk("mrst_outs", {ldata | baddr | bwdata}, 32'h0);
    chk("mrst_pulses", 32'({lvalid, berr, we, be}), 32'd0);
    tick();
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_pulses", 32'({lvalid, berr, mis, req, stall}), 32'd0);
      chk("stale_data", ldata, 32'h0);
      tick();
      rvalid = 1'b0;
    end

    access("lw_post", 1, 0, 2'b10, 0, 32'h104, 32'h0, 0, 0, 32'hCAFEF00D, 0,
           4'b1111, 32'h0, 2'd1, 32'hCAFEF00D);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
